// File: rtl/fp_calc_pkg.sv
// Shared constants and types for the calculator's floating-point datapath.
// Used by the alignment shifter, priority encoder and normaliser.
package fp_calc_pkg;

  localparam int MANT_W = 24;
  localparam int SH_W   = 6;
  localparam int MAX_SH = MANT_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/mant_align_shifter_if.sv
// Request/result bundle between the exponent-compare logic and the
// mantissa alignment shifter.
interface mant_align_shifter_if #(
  parameter int WIDTH = fp_calc_pkg::MANT_W,
  parameter int SH_W  = fp_calc_pkg::SH_W
);

  logic             start;
  logic [WIDTH-1:0] mant_in;
  logic [SH_W-1:0]  shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] mant_out;
  logic             guard;
  logic             round;
  logic             sticky;

  modport master (
    output start,
    output mant_in,
    output shamt,
    input  busy,
    input  done,
    input  mant_out,
    input  guard,
    input  round,
    input  sticky
  );

  modport slave (
    input  start,
    input  mant_in,
    input  shamt,
    output busy,
    output done,
    output mant_out,
    output guard,
    output round,
    output sticky
  );

endinterface

// File: rtl/mant_align_shifter.sv
// Bit-serial right shifter that aligns the smaller mantissa before add/sub,
// producing guard, round and sticky bits for the rounding stage.
module mant_align_shifter #(
  parameter int WIDTH  = fp_calc_pkg::MANT_W,
  parameter int SH_W   = fp_calc_pkg::SH_W,
  parameter int MAX_SH = WIDTH + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mant_align_shifter_if.slave  bus
);

  import fp_calc_pkg::*;

  localparam int CNT_W = $clog2(MAX_SH + 1);

  state_e             r_state;
  logic [WIDTH-1:0]   r_m;
  logic               r_g;
  logic               r_r;
  logic               r_s;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_clamp;
  logic [CNT_W-1:0]   w_cnt_ld;

  // Past MAX_SH every bit has already been folded into sticky.
  assign w_clamp  = 32'(bus.shamt) >= 32'(MAX_SH);
  assign w_cnt_ld = w_clamp ? CNT_W'(MAX_SH)
                            : CNT_W'(bus.shamt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_g     <= 1'b0;
      r_r     <= 1'b0;
      r_s     <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_m     <= bus.mant_in;
            r_g     <= 1'b0;
            r_r     <= 1'b0;
            r_s     <= 1'b0;
            r_cnt   <= w_cnt_ld;
            r_state <= (w_cnt_ld != '0) ? SHIFT : DONE;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_s   <= r_s | r_r;
          r_r   <= r_g;
          r_g   <= r_m[0];
          r_m   <= {1'b0, r_m[WIDTH-1:1]};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (r_state == SHIFT);
  assign bus.done     = (r_state == DONE);
  assign bus.mant_out = r_m;
  assign bus.guard    = r_g;
  assign bus.round    = r_r;
  assign bus.sticky   = r_s;

endmodule

// File: tb/tb_mant_align_shifter.sv
// Directed and random checks of mant_align_shifter against an
// arithmetic model of right shift with guard/round/sticky.
module tb_mant_align_shifter;

  import fp_calc_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mant_align_shifter_if #(.WIDTH(MANT_W), .SH_W(SH_W)) bus ();

  mant_align_shifter #(
    .WIDTH (MANT_W),
    .SH_W  (SH_W),
    .MAX_SH(MAX_SH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [26:0] ref_align(logic [23:0] mi, int sh);
    int n;
    longint unsigned v, mq, g, r, s;
    n  = (sh > MAX_SH) ? MAX_SH : sh;
    v  = longint'(mi);
    mq = v >> n;
    g  = (n >= 1) ? ((v >> (n - 1)) & 64'd1) : 64'd0;
    r  = (n >= 2) ? ((v >> (n - 2)) & 64'd1) : 64'd0;
    s  = (n >= 3) ? 64'((v & ((64'd1 << (n - 2)) - 64'd1)) != 0) : 64'd0;
    return {mq[23:0], g[0], r[0], s[0]};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_res(string tag, logic [23:0] mi, int sh);
    logic [26:0] e;
    e = ref_align(mi, sh);
    chk({tag, ".mant"}, 64'(bus.mant_out), 64'(e[26:3]));
    chk({tag, ".g"}, 64'(bus.guard), 64'(e[2]));
    chk({tag, ".r"}, 64'(bus.round), 64'(e[1]));
    chk({tag, ".s"}, 64'(bus.sticky), 64'(e[0]));
  endtask

  task automatic check_zero(string tag);
    chk({tag, ".busy"}, 64'(bus.busy), 64'd0);
    chk({tag, ".done"}, 64'(bus.done), 64'd0);
    chk({tag, ".zero"},
        64'({bus.mant_out, bus.guard, bus.round, bus.sticky}), 64'd0);
  endtask

  // Issue one request and wait for its done, checking latency and result.
  task automatic run_op(string tag, logic [23:0] mi, int sh);
    int n, k, nb;
    n  = (sh > MAX_SH) ? MAX_SH : sh;
    k  = 0;
    nb = 0;
    bus.start   = 1'b1;
    bus.mant_in = mi;
    bus.shamt   = SH_W'(sh);
    tick;
    bus.start   = 1'b0;
    bus.mant_in = 24'($urandom);
    bus.shamt   = SH_W'($urandom);
    while (bus.done !== 1'b1 && k < 100) begin
      if (bus.busy === 1'b1) nb++;
      tick;
      k++;
    end
    chk({tag, ".lat"}, 64'(k), 64'(n));
    chk({tag, ".busycyc"}, 64'(nb), 64'(n));
    check_res(tag, mi, sh);
    tick;
    chk({tag, ".donepulse"}, 64'(bus.done), 64'd0);
    check_res({tag, ".hold"}, mi, sh);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen_done;
    int   k;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.mant_in = '0;
    bus.shamt   = '0;
    tick;
    tick;
    check_zero("reset");
    rst = 1'b0;
    tick;
    check_zero("idle");

    run_op("sh1", 24'h800000, 1);
    run_op("sh0", 24'hABCDEF, 0);
    run_op("seven2", 24'h000007, 2);
    run_op("seven3", 24'h000007, 3);
    run_op("clamp40", 24'hFFFFFF, 40);
    run_op("full24", 24'hFFFFFF, 24);
    run_op("full25", 24'hFFFFFF, 25);
    run_op("full26", 24'hFFFFFF, 26);
    run_op("clamp63", 24'hFFFFFF, 63);
    run_op("msb24", 24'h800000, 24);
    run_op("zero40", 24'h000000, 40);
    run_op("zero5", 24'h000000, 5);

    // Back-to-back: start during A's shift is dropped, B enters on A's done.
    bus.start   = 1'b1;
    bus.mant_in = 24'h000010;
    bus.shamt   = SH_W'(4);
    tick;
    chk("b2b.A.busy", 64'(bus.busy), 64'd1);
    bus.mant_in = 24'hFFFFFF;
    bus.shamt   = SH_W'(0);
    tick;
    bus.start = 1'b0;
    k = 1;
    while (bus.done !== 1'b1 && k < 100) begin
      tick;
      k++;
    end
    chk("b2b.A.lat", 64'(k), 64'd4);
    check_res("b2b.A", 24'h000010, 4);
    bus.start   = 1'b1;
    bus.mant_in = 24'h000003;
    bus.shamt   = SH_W'(1);
    tick;
    bus.start = 1'b0;
    chk("b2b.B.nogap", 64'(bus.busy), 64'd1);
    tick;
    chk("b2b.B.done", 64'(bus.done), 64'd1);
    check_res("b2b.B", 24'h000003, 1);
    tick;

    // Reset in the middle of a shift aborts it without a done pulse.
    bus.start   = 1'b1;
    bus.mant_in = 24'hFFFFFF;
    bus.shamt   = SH_W'(10);
    tick;
    bus.start = 1'b0;
    repeat (4) tick;
    chk("abort.busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_zero("abort");
    seen_done = 1'b0;
    repeat (12) begin
      tick;
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    chk("abort.nodone", 64'(seen_done), 64'd0);
    run_op("after_abort", 24'h123456, 7);

    for (int i = 0; i < 30; i++) begin
      logic [23:0] mi;
      int          sh;
      mi = ($urandom_range(0, 4) == 0) ? 24'd0 : 24'($urandom);
      sh = int'($urandom_range(0, 63));
      run_op($sformatf("rnd%0d", i), mi, sh);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
